complex_fix_mac_sched: RTL and testbench

- Parametrised successor to the clocked complex fixed-point multiplier: computes x*y or x*conj(y) on explicit Q-format operands.
- Multiplier count is a parameter (1, 2 or 4 real multipliers), trading area against latency.
- Full-precision accumulation of partial products is followed by a single configurable rounding step and saturation, with per-component overflow flags.
- Sits in the gate-application datapath wherever complex amplitudes are multiplied by matrix coefficients.

---
 rtl/complex_fix_mac_sched_pkg.sv | 22 ++
 rtl/complex_fix_mac_sched_if.sv | 16 +
 rtl/complex_fix_mac_sched_mul.sv | 10 +
 rtl/complex_fix_mac_sched_round_sat.sv | 61 ++++++
 rtl/complex_fix_mac_sched.sv | 175 +++++++++++++++++
 tb/tb_complex_fix_mac_sched.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/complex_fix_mac_sched_pkg.sv
// Shared types and helpers for the sequenced complex fixed-point multiplier.
package cfx_pkg;
    localparam int REAL = 0;
    localparam int IMAG = 1;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2
    } round_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROD = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Two full products plus one carry bit hold any re/im sum exactly.
    function automatic int cfx_acc_width(input int in_bits);
        return 2 * in_bits + 1;
    endfunction
endpackage

// File: rtl/complex_fix_mac_sched_if.sv
// Operand/result bundle of the complex multiplier; index 0 = real, 1 = imag.
interface complex_fix_mac_sched_if #(
    parameter int IN_BITS  = 37,
    parameter int OUT_BITS = 38
);
    logic signed [IN_BITS-1:0]  x   [0:1];
    logic signed [IN_BITS-1:0]  y   [0:1];
    logic                       conj;
    logic                       ready;
    logic                       available;
    logic signed [OUT_BITS-1:0] out [0:1];
    logic [1:0]                 sat;

    modport master (output x, y, conj, ready, input available, out, sat);
    modport slave  (input x, y, conj, ready, output available, out, sat);
endinterface

// File: rtl/complex_fix_mac_sched_mul.sv
// Full-width signed real product, no rounding.
module cfx_fix_mul #(
    parameter int W = 37
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/complex_fix_mac_sched_round_sat.sv
// Single rounding shift by SH followed by clamp or wrap to OUT_BITS.
module cfx_round_sat
    import cfx_pkg::*;
#(
    parameter int          IN_W       = 75,
    parameter int          SH         = 35,
    parameter int          OUT_BITS   = 38,
    parameter round_mode_t ROUND_MODE = RND_HALF_UP,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic signed [IN_W-1:0]     din,
    output logic signed [OUT_BITS-1:0] dout,
    output logic                       ovf
);
    localparam logic signed [IN_W:0] WIDE_MAX = {{(IN_W+2-OUT_BITS){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [IN_W:0] WIDE_MIN = {{(IN_W+2-OUT_BITS){1'b1}}, {(OUT_BITS-1){1'b0}}};
    localparam logic signed [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    logic signed [IN_W:0] floor_s;
    logic signed [IN_W:0] rnd_s;
    logic                 inc_s;

    if (SH == 0) begin : g_no_shift
        assign floor_s = (IN_W+1)'(din);
        assign inc_s   = 1'b0;
    end else begin : g_shift
        localparam logic [IN_W-1:0] REST_MASK = (IN_W'(1) << (SH-1)) - IN_W'(1);
        logic half_s;
        logic rest_s;
        assign floor_s = (IN_W+1)'(din >>> SH);
        assign half_s  = din[SH-1];
        assign rest_s  = |(din & REST_MASK);

        // Round-up decision from the discarded fraction bits.
        always_comb begin
            case (ROUND_MODE)
                RND_TRUNC:     inc_s = 1'b0;
                RND_HALF_UP:   inc_s = half_s;
                RND_HALF_EVEN: inc_s = half_s & (rest_s | floor_s[0]);
                default:       inc_s = 1'b0;
            endcase
        end
    end

    // Range check and clamp/wrap of the rounded value.
    always_comb begin
        rnd_s = floor_s + (IN_W+1)'(inc_s);
        dout  = rnd_s[OUT_BITS-1:0];
        ovf   = 1'b0;
        if (rnd_s > WIDE_MAX) begin
            ovf  = 1'b1;
            dout = SATURATE ? OUT_MAX : rnd_s[OUT_BITS-1:0];
        end else if (rnd_s < WIDE_MIN) begin
            ovf  = 1'b1;
            dout = SATURATE ? OUT_MIN : rnd_s[OUT_BITS-1:0];
        end else begin
            ovf  = 1'b0;
        end
    end
endmodule

// File: rtl/complex_fix_mac_sched.sv
// Complex multiply x*y or x*conj(y) with NUM_MULTS real multipliers time-shared
// over 4/NUM_MULTS product cycles, then one round/saturate cycle.
module complex_fix_mac_sched
    import cfx_pkg::*;
#(
    parameter int          IN_BITS    = 37,
    parameter int          IN_FRAC    = 35,
    parameter int          OUT_BITS   = 38,
    parameter int          OUT_FRAC   = 35,
    parameter int          NUM_MULTS  = 2,
    parameter round_mode_t ROUND_MODE = RND_HALF_UP,
    parameter bit          SATURATE   = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    complex_fix_mac_sched_if.slave  bus
);
    localparam int P     = 4 / NUM_MULTS;
    localparam int ACC_W = cfx_acc_width(IN_BITS);
    localparam int SH    = 2 * IN_FRAC - OUT_FRAC;

    if (!(NUM_MULTS == 1 || NUM_MULTS == 2 || NUM_MULTS == 4)) begin : g_bad_mults
        $error("complex_fix_mac_sched: NUM_MULTS must be 1, 2 or 4");
    end
    if (SH < 0) begin : g_bad_frac
        $error("complex_fix_mac_sched: 2*IN_FRAC-OUT_FRAC must be >= 0");
    end

    state_t                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        avail_q, avail_d;
    logic                        conj_q, conj_d;
    logic signed [IN_BITS-1:0]   x_q [0:1], x_d [0:1];
    logic signed [IN_BITS-1:0]   y_q [0:1], y_d [0:1];
    logic signed [ACC_W-1:0]     acc_q [0:1], acc_d [0:1];
    logic signed [OUT_BITS-1:0]  out_q [0:1], out_d [0:1];
    logic [1:0]                  sat_q, sat_d;
    logic signed [IN_BITS-1:0]   ma_s [NUM_MULTS];
    logic signed [IN_BITS-1:0]   mb_s [NUM_MULTS];
    logic signed [2*IN_BITS-1:0] prod_s [NUM_MULTS];
    logic signed [ACC_W-1:0]     sum_s [0:1];
    logic signed [OUT_BITS-1:0]  rnd_s [0:1];
    logic [1:0]                  ovf_s;

    // Product slot k: 0=ac, 1=bd, 2=bc, 3=ad.
    function automatic logic [1:0] prod_idx(input logic [1:0] cnt, input int m);
        return 2'(int'(cnt) * NUM_MULTS + m);
    endfunction

    // Operand routing for each multiplier in the current product cycle.
    always_comb begin
        for (int m = 0; m < NUM_MULTS; m++) begin
            case (prod_idx(cnt_q, m))
                2'd0:    begin ma_s[m] = x_q[REAL]; mb_s[m] = y_q[REAL]; end
                2'd1:    begin ma_s[m] = x_q[IMAG]; mb_s[m] = y_q[IMAG]; end
                2'd2:    begin ma_s[m] = x_q[IMAG]; mb_s[m] = y_q[REAL]; end
                default: begin ma_s[m] = x_q[REAL]; mb_s[m] = y_q[IMAG]; end
            endcase
        end
    end

    for (genvar m = 0; m < NUM_MULTS; m++) begin : g_mul
        cfx_fix_mul #(.W(IN_BITS)) u_mul (.a(ma_s[m]), .b(mb_s[m]), .p(prod_s[m]));
    end

    // Signed contribution of this cycle's products to re and im.
    always_comb begin
        sum_s[REAL] = '0;
        sum_s[IMAG] = '0;
        for (int m = 0; m < NUM_MULTS; m++) begin
            case (prod_idx(cnt_q, m))
                2'd0: sum_s[REAL] = sum_s[REAL] + ACC_W'(prod_s[m]);
                2'd1: begin
                    if (conj_q) sum_s[REAL] = sum_s[REAL] + ACC_W'(prod_s[m]);
                    else        sum_s[REAL] = sum_s[REAL] - ACC_W'(prod_s[m]);
                end
                2'd2: sum_s[IMAG] = sum_s[IMAG] + ACC_W'(prod_s[m]);
                default: begin
                    if (conj_q) sum_s[IMAG] = sum_s[IMAG] - ACC_W'(prod_s[m]);
                    else        sum_s[IMAG] = sum_s[IMAG] + ACC_W'(prod_s[m]);
                end
            endcase
        end
    end

    cfx_round_sat #(.IN_W(ACC_W), .SH(SH), .OUT_BITS(OUT_BITS), .ROUND_MODE(ROUND_MODE),
                    .SATURATE(SATURATE))
        u_rs_re (.din(acc_q[REAL]), .dout(rnd_s[REAL]), .ovf(ovf_s[0]));
    cfx_round_sat #(.IN_W(ACC_W), .SH(SH), .OUT_BITS(OUT_BITS), .ROUND_MODE(ROUND_MODE),
                    .SATURATE(SATURATE))
        u_rs_im (.din(acc_q[IMAG]), .dout(rnd_s[IMAG]), .ovf(ovf_s[1]));

    // Sequencer next state: IDLE -> PROD (P cycles) -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        avail_d = avail_q;
        conj_d  = conj_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        out_d   = out_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ready) begin
                    state_d     = ST_PROD;
                    cnt_d       = 2'd0;
                    avail_d     = 1'b0;
                    conj_d      = bus.conj;
                    x_d[REAL]   = bus.x[REAL];
                    x_d[IMAG]   = bus.x[IMAG];
                    y_d[REAL]   = bus.y[REAL];
                    y_d[IMAG]   = bus.y[IMAG];
                    acc_d[REAL] = '0;
                    acc_d[IMAG] = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROD: begin
                acc_d[REAL] = acc_q[REAL] + sum_s[REAL];
                acc_d[IMAG] = acc_q[IMAG] + sum_s[IMAG];
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'(P - 1)) state_d = ST_FIN;
                else                    state_d = ST_PROD;
            end
            ST_FIN: begin
                out_d[REAL] = rnd_s[REAL];
                out_d[IMAG] = rnd_s[IMAG];
                sat_d       = ovf_s;
                avail_d     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                avail_d = 1'b1;
            end
        endcase
    end

    // State, operand, accumulator and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            avail_q     <= 1'b1;
            conj_q      <= 1'b0;
            x_q[REAL]   <= '0;
            x_q[IMAG]   <= '0;
            y_q[REAL]   <= '0;
            y_q[IMAG]   <= '0;
            acc_q[REAL] <= '0;
            acc_q[IMAG] <= '0;
            out_q[REAL] <= '0;
            out_q[IMAG] <= '0;
            sat_q       <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            avail_q <= avail_d;
            conj_q  <= conj_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.available = avail_q;
    assign bus.out[REAL] = out_q[REAL];
    assign bus.out[IMAG] = out_q[IMAG];
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_complex_fix_mac_sched.sv
// Randomised bench for three configurations of complex_fix_mac_sched against an arithmetic model.
module tb_complex_fix_mac_sched;
    import cfx_pkg::*;

    localparam int IB = 16;
    localparam int OB = 18;

    logic clk;
    logic reset;
    logic signed [IB-1:0] xr, xi, yr, yi;
    logic cj, rdy;

    int n_vec = 0;
    int n_err = 0;
    logic signed [63:0] last_re [3];
    logic signed [63:0] last_im [3];
    logic [1:0]         last_sat [3];

    complex_fix_mac_sched_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus1 ();
    complex_fix_mac_sched_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus2 ();
    complex_fix_mac_sched_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus4 ();

    assign bus1.x[0] = xr; assign bus1.x[1] = xi; assign bus1.y[0] = yr; assign bus1.y[1] = yi;
    assign bus2.x[0] = xr; assign bus2.x[1] = xi; assign bus2.y[0] = yr; assign bus2.y[1] = yi;
    assign bus4.x[0] = xr; assign bus4.x[1] = xi; assign bus4.y[0] = yr; assign bus4.y[1] = yi;
    assign bus1.conj = cj; assign bus2.conj = cj; assign bus4.conj = cj;
    assign bus1.ready = rdy; assign bus2.ready = rdy; assign bus4.ready = rdy;

    complex_fix_mac_sched #(.IN_BITS(IB), .IN_FRAC(14), .OUT_BITS(OB), .OUT_FRAC(14),
        .NUM_MULTS(1), .ROUND_MODE(RND_HALF_UP), .SATURATE(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    complex_fix_mac_sched #(.IN_BITS(IB), .IN_FRAC(14), .OUT_BITS(OB), .OUT_FRAC(14),
        .NUM_MULTS(2), .ROUND_MODE(RND_TRUNC), .SATURATE(1'b1))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    complex_fix_mac_sched #(.IN_BITS(IB), .IN_FRAC(14), .OUT_BITS(OB), .OUT_FRAC(14),
        .NUM_MULTS(4), .ROUND_MODE(RND_HALF_EVEN), .SATURATE(1'b0))
        dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance table: 0 -> 1 mult/HALF_UP/sat, 1 -> 2 mults/TRUNC/sat, 2 -> 4 mults/HALF_EVEN/wrap.
    function automatic int nm_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction
    function automatic int mode_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 2;
    endfunction
    function automatic bit sate_of(input int i);
        return (i != 2);
    endfunction

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Real value v / 2^14 rounded per mode, then clamped or wrapped to 18 bits.
    function automatic longint round_sat(input longint v, input int mode, input bit satv,
                                         output bit ov);
        longint q, rem, r;
        q = v / 16384;
        if (v < 0 && q * 16384 != v) q = q - 1;
        rem = v - q * 16384;
        case (mode)
            1:       r = (rem >= 8192) ? q + 1 : q;
            2:       r = (rem > 8192 || (rem == 8192 && (q % 2) != 0)) ? q + 1 : q;
            default: r = q;
        endcase
        ov = (r > 131071) || (r < -131072);
        if (ov && satv) begin
            r = (r > 0) ? 131071 : -131072;
        end else if (ov) begin
            r = r % 262144;
            if (r >= 131072) r = r - 262144;
            if (r < -131072) r = r + 262144;
        end
        return r;
    endfunction

    function automatic void model(input int i, input longint a, b, c, d, input bit cjv,
                                  output logic signed [63:0] er, ei, output logic [1:0] es);
        longint re, im;
        bit ovr, ovi;
        re = cjv ? a * c + b * d : a * c - b * d;
        im = cjv ? b * c - a * d : b * c + a * d;
        er = round_sat(re, mode_of(i), sate_of(i), ovr);
        ei = round_sat(im, mode_of(i), sate_of(i), ovi);
        es = {ovi, ovr};
    endfunction

    function automatic void observe(input int i, output logic av, output logic signed [63:0] ore,
                                    output logic signed [63:0] oim, output logic [1:0] os);
        case (i)
            0: begin av = bus1.available; ore = bus1.out[0]; oim = bus1.out[1]; os = bus1.sat; end
            1: begin av = bus2.available; ore = bus2.out[0]; oim = bus2.out[1]; os = bus2.sat; end
            default: begin av = bus4.available; ore = bus4.out[0]; oim = bus4.out[1]; os = bus4.sat; end
        endcase
    endfunction

    task automatic check_inst(input int i, input string tag, input logic exp_av,
                              input logic signed [63:0] ere, eim, input logic [1:0] es,
                              input bit data);
        logic av;
        logic signed [63:0] ore, oim;
        logic [1:0] os;
        observe(i, av, ore, oim, os);
        check_val($sformatf("m%0d %s avail", nm_of(i), tag), {63'd0, av}, {63'd0, exp_av});
        if (data) begin
            check_val($sformatf("m%0d %s re", nm_of(i), tag), ore, ere);
            check_val($sformatf("m%0d %s im", nm_of(i), tag), oim, eim);
            check_val($sformatf("m%0d %s sat", nm_of(i), tag), {62'd0, os}, {62'd0, es});
        end
    endtask

    function automatic longint rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return longint'(v);
    endfunction

    task automatic set_expect(input longint a, b, c, d, input bit cjv);
        for (int i = 0; i < 3; i++) model(i, a, b, c, d, cjv, last_re[i], last_im[i], last_sat[i]);
    endtask

    // One operation: start, scramble inputs, optional busy ready pulse, check latency and result.
    task automatic run_op(input longint a, b, c, d, input bit cjv, input bit poke);
        set_expect(a, b, c, d, cjv);
        xr = 16'(a); xi = 16'(b); yr = 16'(c); yi = 16'(d); cj = cjv; rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        xr = 16'($urandom); xi = 16'($urandom); yr = 16'($urandom); yi = 16'($urandom);
        cj = 1'($urandom);
        for (int i = 0; i < 3; i++) check_inst(i, "start", 1'b0, 0, 0, 2'b00, 1'b0);
        if (poke) rdy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            rdy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                int p;
                p = 4 / nm_of(i);
                check_inst(i, $sformatf("lat%0d", k), (k >= p + 1), last_re[i], last_im[i],
                           last_sat[i], (k >= p + 1));
            end
        end
    endtask

    initial begin
        reset = 1'b1; rdy = 1'b0; cj = 1'b0;
        xr = '0; xi = '0; yr = '0; yi = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_inst(i, "rst", 1'b1, 0, 0, 2'b00, 1'b1);
        @(negedge clk); reset = 1'b0;

        run_op(8192, 8192, 8192, -8192, 1'b0, 1'b0);
        run_op(8192, 8192, 8192, -8192, 1'b1, 1'b1);
        run_op(-32768, -32768, -32768, -32768, 1'b0, 1'b0);
        run_op(1, 0, 8192, 0, 1'b0, 1'b0);
        run_op(3, 0, 8192, 0, 1'b0, 1'b1);
        run_op(-1, 0, 8192, 0, 1'b0, 1'b0);

        // Hold: inputs wiggle with ready low, results must not move.
        for (int n = 0; n < 10; n++) begin
            xr = 16'($urandom); xi = 16'($urandom); yr = 16'($urandom); yi = 16'($urandom);
            cj = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                check_inst(i, "hold", 1'b1, last_re[i], last_im[i], last_sat[i], 1'b1);
        end

        // Back-to-back: ready held high, one issue every P+2 cycles.
        begin
            longint a, b, c, d;
            a = rnd16(); b = rnd16(); c = rnd16(); d = rnd16();
            set_expect(a, b, c, d, 1'b1);
            xr = 16'(a); xi = 16'(b); yr = 16'(c); yi = 16'(d); cj = 1'b1; rdy = 1'b1;
            for (int j = 0; j < 20; j++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++) begin
                    int p;
                    bit done;
                    p = 4 / nm_of(i);
                    done = ((j % (p + 2)) == p + 1);
                    check_inst(i, $sformatf("b2b%0d", j), done, last_re[i], last_im[i],
                               last_sat[i], done);
                end
            end
            rdy = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end

        // Reset in the middle of an operation aborts it.
        xr = 16'(rnd16()); xi = 16'(rnd16()); yr = 16'(rnd16()); yi = 16'(rnd16()); rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_inst(i, "abort", 1'b1, 0, 0, 2'b00, 1'b1);
        @(negedge clk); reset = 1'b0;
        run_op(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0, 1'b0);

        // Random operations, including a forced extreme corner.
        for (int n = 0; n < 40; n++)
            run_op(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        run_op(32767, -32768, -32768, 32767, 1'b1, 1'b1);
        run_op(-32768, 32767, -32768, -32768, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
